// File: rtl/snoop_coherence_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_coherence_ctrl
//  Brief    : Direct-mapped MSI/MESI coherence controller for one private
//             cache. Services local CPU requests and bus snoops, and issues
//             bus requests and write-backs over valid/ready handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module snoop_coherence_ctrl #(
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = 6,
    parameter int MESI_EN   = 0
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   cpu_valid,
    input  logic                   cpu_write,
    input  logic [ADDR_W-1:0]      cpu_addr,
    output logic                   cpu_ready,
    input  logic                   snoop_valid,
    input  logic [1:0]             snoop_op,
    input  logic [ADDR_W-1:0]      snoop_addr,
    output logic                   snoop_ready,
    output logic                   bus_req_valid,
    output logic [1:0]             bus_req_op,
    output logic [ADDR_W-1:0]      bus_req_addr,
    input  logic                   bus_req_ready,
    input  logic                   bus_shared,
    output logic                   wb_valid,
    output logic [ADDR_W-1:0]      wb_addr,
    input  logic                   wb_ready,
    output logic [2*NUM_LINES-1:0] line_state
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [1:0] c_st_i = 2'b00;
    localparam logic [1:0] c_st_m = 2'b01;
    localparam logic [1:0] c_st_s = 2'b10;
    localparam logic [1:0] c_st_e = 2'b11;

    localparam logic [1:0] c_op_rm  = 2'b00;
    localparam logic [1:0] c_op_inv = 2'b01;
    localparam logic [1:0] c_op_wm  = 2'b10;
    localparam logic [1:0] c_op_nop = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WB_WAIT  = 2'd1,
        S_REQ_WAIT = 2'd2
    } fsm_t;

    fsm_t              r_fsm, w_fsm_nxt;

    logic [1:0]        r_line [NUM_LINES];
    logic [TAG_W-1:0]  r_tag  [NUM_LINES];

    logic              r_bus_req_valid, w_bus_req_valid_nxt;
    logic [1:0]        r_bus_req_op,    w_bus_req_op_nxt;
    logic [ADDR_W-1:0] r_bus_req_addr,  w_bus_req_addr_nxt;
    logic              r_wb_valid,      w_wb_valid_nxt;
    logic [ADDR_W-1:0] r_wb_addr,       w_wb_addr_nxt;

    // Miss request parked behind a victim write-back
    logic              r_pend_req,  w_pend_req_nxt;
    logic [1:0]        r_pend_op,   w_pend_op_nxt;
    logic [ADDR_W-1:0] r_pend_addr, w_pend_addr_nxt;

    // Single write port into the tag/state array
    logic              w_line_we;
    logic              w_tag_we;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [1:0]        w_line_val;
    logic [TAG_W-1:0]  w_tag_val;

    logic [IDX_W-1:0]  w_snp_idx, w_cpu_idx, w_req_idx;
    logic [TAG_W-1:0]  w_snp_tag, w_cpu_tag, w_req_tag;
    logic [1:0]        w_snp_st, w_cpu_st;
    logic              w_snp_hit, w_cpu_hit;

    assign w_snp_idx = snoop_addr[IDX_W-1:0];
    assign w_snp_tag = snoop_addr[ADDR_W-1:IDX_W];
    assign w_cpu_idx = cpu_addr[IDX_W-1:0];
    assign w_cpu_tag = cpu_addr[ADDR_W-1:IDX_W];
    assign w_req_idx = r_bus_req_addr[IDX_W-1:0];
    assign w_req_tag = r_bus_req_addr[ADDR_W-1:IDX_W];

    assign w_snp_st  = r_line[w_snp_idx];
    assign w_cpu_st  = r_line[w_cpu_idx];
    assign w_snp_hit = (w_snp_st != c_st_i) && (r_tag[w_snp_idx] == w_snp_tag);
    assign w_cpu_hit = (w_cpu_st != c_st_i) && (r_tag[w_cpu_idx] == w_cpu_tag);

    // Snoops win over the CPU whenever both arrive in the same idle cycle
    assign snoop_ready = (r_fsm == S_IDLE);
    assign cpu_ready   = (r_fsm == S_IDLE) && !snoop_valid;

    assign bus_req_valid = r_bus_req_valid;
    assign bus_req_op    = r_bus_req_op;
    assign bus_req_addr  = r_bus_req_addr;
    assign wb_valid      = r_wb_valid;
    assign wb_addr       = r_wb_addr;

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line_state
            assign line_state[2*gi +: 2] = r_line[gi];
        end
    endgenerate

    // Next-state, handshake outputs and array update selection
    always_comb begin
        w_fsm_nxt           = r_fsm;
        w_bus_req_valid_nxt = r_bus_req_valid;
        w_bus_req_op_nxt    = r_bus_req_op;
        w_bus_req_addr_nxt  = r_bus_req_addr;
        w_wb_valid_nxt      = r_wb_valid;
        w_wb_addr_nxt       = r_wb_addr;
        w_pend_req_nxt      = r_pend_req;
        w_pend_op_nxt       = r_pend_op;
        w_pend_addr_nxt     = r_pend_addr;
        w_line_we           = 1'b0;
        w_tag_we            = 1'b0;
        w_wr_idx            = '0;
        w_line_val          = c_st_i;
        w_tag_val           = '0;

        case (r_fsm)
            S_IDLE: begin
                if (snoop_valid) begin
                    if (w_snp_hit && (snoop_op != c_op_nop)) begin
                        w_wr_idx   = w_snp_idx;
                        w_line_we  = 1'b1;
                        w_line_val = (snoop_op == c_op_rm) ? c_st_s : c_st_i;
                        // Only dirty data leaves the cache, and not on a pure invalidate
                        if ((w_snp_st == c_st_m) && (snoop_op != c_op_inv)) begin
                            w_wb_valid_nxt = 1'b1;
                            w_wb_addr_nxt  = snoop_addr;
                            w_pend_req_nxt = 1'b0;
                            w_fsm_nxt      = S_WB_WAIT;
                        end
                    end
                end else if (cpu_valid) begin
                    if (w_cpu_hit) begin
                        if (cpu_write && (w_cpu_st == c_st_e)) begin
                            w_wr_idx   = w_cpu_idx;
                            w_line_we  = 1'b1;
                            w_line_val = c_st_m;
                        end else if (cpu_write && (w_cpu_st == c_st_s)) begin
                            w_bus_req_valid_nxt = 1'b1;
                            w_bus_req_op_nxt    = c_op_inv;
                            w_bus_req_addr_nxt  = cpu_addr;
                            w_fsm_nxt           = S_REQ_WAIT;
                        end
                    end else if (w_cpu_st == c_st_m) begin
                        // Dirty victim must reach memory before the refill request
                        w_wb_valid_nxt  = 1'b1;
                        w_wb_addr_nxt   = {r_tag[w_cpu_idx], w_cpu_idx};
                        w_pend_req_nxt  = 1'b1;
                        w_pend_op_nxt   = cpu_write ? c_op_wm : c_op_rm;
                        w_pend_addr_nxt = cpu_addr;
                        w_fsm_nxt       = S_WB_WAIT;
                    end else begin
                        w_bus_req_valid_nxt = 1'b1;
                        w_bus_req_op_nxt    = cpu_write ? c_op_wm : c_op_rm;
                        w_bus_req_addr_nxt  = cpu_addr;
                        w_fsm_nxt           = S_REQ_WAIT;
                    end
                end
            end

            S_WB_WAIT: begin
                if (wb_ready) begin
                    w_wb_valid_nxt = 1'b0;
                    if (r_pend_req) begin
                        w_bus_req_valid_nxt = 1'b1;
                        w_bus_req_op_nxt    = r_pend_op;
                        w_bus_req_addr_nxt  = r_pend_addr;
                        w_pend_req_nxt      = 1'b0;
                        w_fsm_nxt           = S_REQ_WAIT;
                    end else begin
                        w_fsm_nxt = S_IDLE;
                    end
                end
            end

            S_REQ_WAIT: begin
                if (bus_req_ready) begin
                    w_bus_req_valid_nxt = 1'b0;
                    w_wr_idx            = w_req_idx;
                    w_tag_val           = w_req_tag;
                    w_line_we           = 1'b1;
                    case (r_bus_req_op)
                        c_op_inv: w_line_val = c_st_m;
                        c_op_wm: begin
                            w_tag_we   = 1'b1;
                            w_line_val = c_st_m;
                        end
                        default: begin
                            w_tag_we   = 1'b1;
                            w_line_val = ((MESI_EN != 0) && !bus_shared) ? c_st_e : c_st_s;
                        end
                    endcase
                    w_fsm_nxt = S_IDLE;
                end
            end

            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_fsm <= S_IDLE;
        else         r_fsm <= w_fsm_nxt;
    end

    // Registered handshake outputs and parked miss request
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_bus_req_valid <= 1'b0;
            r_bus_req_op    <= 2'b00;
            r_bus_req_addr  <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_addr       <= '0;
            r_pend_req      <= 1'b0;
            r_pend_op       <= 2'b00;
            r_pend_addr     <= '0;
        end else begin
            r_bus_req_valid <= w_bus_req_valid_nxt;
            r_bus_req_op    <= w_bus_req_op_nxt;
            r_bus_req_addr  <= w_bus_req_addr_nxt;
            r_wb_valid      <= w_wb_valid_nxt;
            r_wb_addr       <= w_wb_addr_nxt;
            r_pend_req      <= w_pend_req_nxt;
            r_pend_op       <= w_pend_op_nxt;
            r_pend_addr     <= w_pend_addr_nxt;
        end
    end

    // Tag/state array update
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_line[i] <= c_st_i;
                r_tag[i]  <= '0;
            end
        end else begin
            if (w_line_we) r_line[w_wr_idx] <= w_line_val;
            if (w_tag_we)  r_tag[w_wr_idx]  <= w_tag_val;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snoop_coherence_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snoop_coherence_ctrl
//  Brief    : Scoreboard bench for snoop_coherence_ctrl. Expected bus and
//             write-back transactions are queued at stimulus time and popped
//             by a monitor at each DUT handshake. A second MESI instance
//             shares the stimulus for the clean-exclusive cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_coherence_ctrl;

    localparam logic [1:0] c_rm  = 2'b00;
    localparam logic [1:0] c_inv = 2'b01;
    localparam logic [1:0] c_wm  = 2'b10;

    localparam logic [1:0] c_i = 2'b00;
    localparam logic [1:0] c_m = 2'b01;
    localparam logic [1:0] c_s = 2'b10;
    localparam logic [1:0] c_e = 2'b11;

    typedef struct packed {
        logic       kind;   // 0 = bus request, 1 = write-back
        logic [1:0] op;
        logic [5:0] addr;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       cpu_valid, cpu_write;
    logic [5:0] cpu_addr;
    logic       snoop_valid;
    logic [1:0] snoop_op;
    logic [5:0] snoop_addr;
    logic       bus_req_ready, bus_shared, wb_ready;

    logic       cpu_ready, snoop_ready, bus_req_valid, wb_valid;
    logic [1:0] bus_req_op;
    logic [5:0] bus_req_addr, wb_addr;
    logic [7:0] line_state;

    logic       e_cpu_ready, e_snoop_ready, e_bus_req_valid, e_wb_valid;
    logic [1:0] e_bus_req_op;
    logic [5:0] e_bus_req_addr, e_wb_addr;
    logic [7:0] e_line_state;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] saved_ls;

    always #5 clock = ~clock;

    snoop_coherence_ctrl #(.NUM_LINES(4), .ADDR_W(6), .MESI_EN(0)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
        .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_ready(snoop_ready),
        .bus_req_valid(bus_req_valid), .bus_req_op(bus_req_op), .bus_req_addr(bus_req_addr),
        .bus_req_ready(bus_req_ready), .bus_shared(bus_shared),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
        .line_state(line_state)
    );

    snoop_coherence_ctrl #(.NUM_LINES(4), .ADDR_W(6), .MESI_EN(1)) dut_e (
        .clock(clock), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_ready(e_cpu_ready),
        .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_ready(e_snoop_ready),
        .bus_req_valid(e_bus_req_valid), .bus_req_op(e_bus_req_op), .bus_req_addr(e_bus_req_addr),
        .bus_req_ready(bus_req_ready), .bus_shared(bus_shared),
        .wb_valid(e_wb_valid), .wb_addr(e_wb_addr), .wb_ready(wb_ready),
        .line_state(e_line_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic xact(input logic kind, input logic [1:0] op, input logic [5:0] addr);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_xact actual=%0h required=none", {kind, op, addr});
        end else begin
            e = q.pop_front();
            if ({kind, op, addr} !== {e.kind, e.op, e.addr}) begin
                errors++;
                $display("FAIL xact actual=%0h required=%0h", {kind, op, addr}, {e.kind, e.op, e.addr});
            end
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge
    always @(negedge clock) begin
        if (resetn) begin
            if (bus_req_valid && bus_req_ready) xact(1'b0, bus_req_op, bus_req_addr);
            if (wb_valid && wb_ready)           xact(1'b1, 2'b00, wb_addr);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic kind, input logic [1:0] op, input logic [5:0] addr);
        exp_t e;
        e.kind = kind;
        e.op   = op;
        e.addr = addr;
        q.push_back(e);
    endtask

    task automatic cpu_req(input logic wr, input logic [5:0] a);
        cpu_valid = 1'b1;
        cpu_write = wr;
        cpu_addr  = a;
        #1;
        chk("cpu_ready", cpu_ready, 1);
        tick;
        cpu_valid = 1'b0;
    endtask

    task automatic snoop(input logic [1:0] op, input logic [5:0] a);
        snoop_valid = 1'b1;
        snoop_op    = op;
        snoop_addr  = a;
        #1;
        chk("snoop_ready", snoop_ready, 1);
        tick;
        snoop_valid = 1'b0;
    endtask

    task automatic bus_ack(input logic sh, input int hold);
        int n = 0;
        while (!bus_req_valid && n < 50) begin tick; n++; end
        if (!bus_req_valid) begin
            chk("bus_req_timeout", 0, 1);
        end else begin
            repeat (hold) begin
                chk("bus_req_held", bus_req_valid, 1);
                tick;
            end
            bus_shared    = sh;
            bus_req_ready = 1'b1;
            tick;
            bus_req_ready = 1'b0;
            bus_shared    = 1'b0;
            chk("bus_req_drop", bus_req_valid, 0);
        end
    endtask

    task automatic wb_ack(input int hold);
        int n = 0;
        while (!wb_valid && n < 50) begin tick; n++; end
        if (!wb_valid) begin
            chk("wb_timeout", 0, 1);
        end else begin
            repeat (hold) begin
                chk("wb_held", wb_valid, 1);
                chk("snoop_ready_busy", snoop_ready, 0);
                tick;
            end
            wb_ready = 1'b1;
            tick;
            wb_ready = 1'b0;
            chk("wb_drop", wb_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_addr = '0;
        snoop_valid = 1'b0; snoop_op = 2'b00; snoop_addr = '0;
        bus_req_ready = 1'b0; bus_shared = 1'b0; wb_ready = 1'b0;
        repeat (3) tick;

        // Reset state
        chk("rst_line_state", line_state, 8'h00);
        chk("rst_bus_req_valid", bus_req_valid, 0);
        chk("rst_bus_req_op", bus_req_op, 0);
        chk("rst_bus_req_addr", bus_req_addr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_snoop_ready", snoop_ready, 1);
        resetn = 1'b1;
        tick;

        // Read miss, unshared: S in MSI, E in MESI
        push(1'b0, c_rm, 6'h05);
        cpu_req(1'b0, 6'h05);
        bus_ack(1'b0, 0);
        chk("rd_miss_msi_S", line_state[3:2], c_s);
        chk("rd_miss_mesi_E", e_line_state[3:2], c_e);

        // Write hit on S upgrades via Invalidate; MESI E upgrades silently
        push(1'b0, c_inv, 6'h05);
        cpu_req(1'b1, 6'h05);
        bus_ack(1'b0, 1);
        chk("wr_hit_S_to_M", line_state[3:2], c_m);
        chk("wr_hit_E_to_M", e_line_state[3:2], c_m);
        chk("wr_hit_E_nobus", e_bus_req_valid, 0);
        cpu_req(1'b1, 6'h05);
        chk("wr_hit_M_nobus", bus_req_valid, 0);
        chk("wr_hit_M_idle", cpu_ready, 1);
        chk("wr_hit_M_state", line_state[3:2], c_m);

        // Snoop ReadMiss on M: write-back held while wb_ready stays low
        push(1'b1, 2'b00, 6'h05);
        snoop(c_rm, 6'h05);
        chk("snp_rm_M_to_S", line_state[3:2], c_s);
        chk("snp_wb_addr", wb_addr, 6'h05);
        wb_ack(3);
        chk("snp_wb_done_idle", snoop_ready, 1);

        // Back to M, then conflicting read: victim write-back then ReadMiss
        push(1'b0, c_inv, 6'h05);
        cpu_req(1'b1, 6'h05);
        bus_ack(1'b0, 0);
        chk("refill_M", line_state[3:2], c_m);
        push(1'b1, 2'b00, 6'h05);
        push(1'b0, c_rm, 6'h09);
        wb_ready = 1'b1;
        cpu_req(1'b0, 6'h09);
        chk("victim_wb_valid", wb_valid, 1);
        tick;
        wb_ready = 1'b0;
        chk("victim_wb_sameready_drop", wb_valid, 0);
        bus_ack(1'b1, 0);
        chk("victim_refill_S", line_state[3:2], c_s);
        cpu_req(1'b0, 6'h09);
        chk("new_tag_hit_nobus", bus_req_valid, 0);

        // Reload tag 1 in S (victim not M: direct ReadMiss)
        push(1'b0, c_rm, 6'h05);
        cpu_req(1'b0, 6'h05);
        bus_ack(1'b1, 0);
        chk("reload_S", line_state[3:2], c_s);

        // Same-cycle snoop WriteMiss and CPU read: snoop wins
        snoop_valid = 1'b1; snoop_op = c_wm; snoop_addr = 6'h05;
        cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 6'h05;
        #1;
        chk("prio_cpu_ready", cpu_ready, 0);
        chk("prio_snoop_ready", snoop_ready, 1);
        tick;
        snoop_valid = 1'b0;
        chk("prio_line_I", line_state[3:2], c_i);
        chk("prio_no_wb", wb_valid, 0);
        push(1'b0, c_rm, 6'h05);
        #1;
        chk("prio_cpu_ready_next", cpu_ready, 1);
        tick;
        cpu_valid = 1'b0;
        bus_ack(1'b0, 0);
        chk("prio_refill_S", line_state[3:2], c_s);

        // Ignored op and tag-mismatch snoops leave state untouched
        saved_ls = line_state;
        snoop(2'b11, 6'h05);
        chk("snp_op11_nochange", line_state, saved_ls);
        snoop(c_wm, 6'h0D);
        chk("snp_miss_nochange", line_state, saved_ls);
        chk("snp_miss_no_wb", wb_valid, 0);
        chk("queue_drained", q.size(), 0);

        // Asynchronous reset while waiting on the bus
        push(1'b0, c_rm, 6'h02);
        cpu_req(1'b0, 6'h02);
        chk("pre_rst_req_valid", bus_req_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_req_valid", bus_req_valid, 0);
        chk("async_rst_req_addr", bus_req_addr, 0);
        chk("async_rst_lines", line_state, 8'h00);
        chk("async_rst_lines_e", e_line_state, 8'h00);
        chk("async_rst_snoop_ready", snoop_ready, 1);
        q.delete();
        tick;
        resetn = 1'b1;
        tick;
        chk("post_rst_req_valid", bus_req_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snoop_coherence_ctrl.md
Name: snoop_coherence_ctrl

Overview:
- Parametrised multi-line MSI/MESI coherence controller for one private cache: direct-mapped tag/state array of NUM_LINES entries.
- Services two request sources: local CPU requests, and bus snoop requests from other caches (ReadMiss/Invalidate/WriteMiss).
- Issues bus requests and write-back requests through valid/ready handshakes.
- Sits between the cache data array and the shared snooping bus.

Parameters:
NUM_LINES, 4, number of lines; power of two, >=2
ADDR_W, 6, block address width; index = addr[log2(NUM_LINES)-1:0], tag = remaining upper bits
MESI_EN, 0, 0 = MSI; 1 = adds clean-Exclusive state

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  asynchronous active-low reset
cpu_valid  in  1  CPU request present
cpu_write  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU block address
cpu_ready  out  1  CPU request accepted this cycle (combinational)
snoop_valid  in  1  bus snoop present
snoop_op  in  2  00 ReadMiss, 01 Invalidate, 10 WriteMiss, 11 ignored
snoop_addr  in  ADDR_W  snooped block address
snoop_ready  out  1  snoop accepted this cycle (combinational)
bus_req_valid  out  1  local bus request pending
bus_req_op  out  2  same encoding as snoop_op
bus_req_addr  out  ADDR_W  request address
bus_req_ready  in  1  bus accepts request
bus_shared  in  1  another cache holds the block; sampled at bus_req handshake
wb_valid  out  1  write-back pending
wb_addr  out  ADDR_W  block to write back
wb_ready  in  1  memory accepts write-back
line_state  out  2*NUM_LINES  per-line state, line i at [2i+1:2i]

Behaviour:
- State encoding: I=00, M=01 (modified/dirty), S=10, E=11 (clean exclusive; reachable only if MESI_EN=1).
- Reset (resetn low, async): all lines I, all tags 0, FSM IDLE, bus_req_valid=0, wb_valid=0, bus_req_op=0, addrs=0.
- Hit definition: line[index] state != I and stored tag == address tag.
- Controller FSM states: IDLE, WB_WAIT, REQ_WAIT.
- Handshakes:
  - snoop_ready = (FSM==IDLE).
  - cpu_ready = (FSM==IDLE) && !snoop_valid; snoop has priority in the same cycle.
  - The bus never snoops this cache while bus_req_valid=1.
  - bus_req_* and wb_* are registered and held stable until their ready is seen; each deasserts the cycle after its handshake.
- Snoop, applied at accept, on hit only:
  - M: ReadMiss -> S + write-back; WriteMiss -> I + write-back; Invalidate -> I, no write-back.
  - S: ReadMiss -> S; WriteMiss or Invalidate -> I.
  - E: ReadMiss -> S; WriteMiss or Invalidate -> I; no write-back.
  - Snoop miss or op 11: accepted, no change.
  - Write-back case: next cycle wb_valid=1, wb_addr=snoop_addr, FSM WB_WAIT; on wb_ready -> IDLE.
- CPU, at accept:
  - Read hit: no change.
  - Write hit M: no change.
  - Write hit E: -> M silently, no bus traffic.
  - Write hit S: bus_req Invalidate, FSM REQ_WAIT.
  - Miss with victim in M: wb_valid with victim address {stored tag, index}, FSM WB_WAIT. On wb_ready -> REQ_WAIT with the miss request (ReadMiss for a read, WriteMiss for a write).
  - Miss, victim not M: go directly to REQ_WAIT.
- At bus_req handshake:
  - Invalidate: line -> M.
  - WriteMiss: tag installed, line -> M.
  - ReadMiss: tag installed, line -> E if MESI_EN && !bus_shared, else S.
  - FSM -> IDLE.
- Latency:
  - Hits: 1 cycle.
  - Misses: 1 cycle + write-back wait + request wait.
  - Same-cycle ready allowed: wb_ready may already be high when wb_valid rises; handshake completes that cycle.
- line_state is updated the cycle after the triggering handshake.
- Reset mid-operation: pending requests dropped, all outputs return to reset values immediately.

Test Plan:
- Reset then CPU read 0x05 (index 1, tag 1), bus_shared=0, MESI_EN=0 -> bus_req ReadMiss 0x05; after ready line_state[3:2]=S; same with MESI_EN=1 -> E.
- Line 1 in S (tag 1); CPU write 0x05 -> bus_req Invalidate 0x05, then line M; second write -> no bus_req, cpu_ready high.
- Line 1 in M (tag 1); snoop ReadMiss 0x05 -> wb_valid, wb_addr=0x05, line S; hold wb_ready low 3 cycles -> wb_valid held, snoop_ready low throughout.
- Line 1 in M (tag 1); CPU read 0x09 (tag 2) -> wb 0x05, then bus_req ReadMiss 0x09, final tag 2, state S.
- Same cycle: snoop WriteMiss 0x05 and CPU read 0x05, line in S -> snoop taken, cpu_ready=0, line I; next cycle CPU miss issues ReadMiss.
- Snoop op 11, and snoop to tag-mismatched address -> accepted, line_state unchanged; assert resetn low while in REQ_WAIT -> bus_req_valid=0 immediately, all lines I.
